// File: rtl/dram_diag_loader.sv
`timescale 1ns/1ps
// ============================================================================
// dram_diag_loader
//
// Diagnostic-side writer and readback engine for the IR dispatch RAM (DRAM).
// One load or readback request is taken at a time. The block then walks
// through a short list of diagnostic function "steps". For each step it
// presents a function code (and, for load-side steps, EBUS data) and then
// pulses the diag strobe that the IR board decodes.
//
//   Load list : LDADR(057) XY(060/061) JC(062) JEO(063/064)
//   Read list : LDADR(057) R133 R134 R135
//
// A load with VERIFY=1 runs both lists and compares the readback with the
// written word. A load with VERIFY=0 runs only the load list. A readback
// request runs only the read list.
//
// Ports
//   clk            system clock
//   CROBAR         synchronous active-high reset
//   req_valid      request present
//   req_ready      high only while idle; accept = req_valid & req_ready
//   req_write      1 = load DRAM word, 0 = readback only
//   req_addr       DRAM address [0:8] (bit 8 selects the even/odd half)
//   req_data       word [0:14]: A[0:2] B[3:5] P[6] J1-4[7:10] J7-10[11:14]
//   rsp_valid      one-cycle completion pulse
//   rsp_data       readback word (captured write data for an unverified load)
//   rsp_mismatch   readback differs from written data (verified loads only)
//   busy           high whenever the sequencer is not idle
//   DIAG_FUNC      diagnostic function code (octal)
//   DIAG_STROBE    diag function strobe
//   ebus_drive     loader drives EBUS data
//   ebus_data_out  EBUS drive data; only [0:8] are ever non-zero
//   ebus_data_in   EBUS receive data; only [0:5] are sampled
//
// Step timing: SETUP for SETTLE_CYCLES, STROBE for STROBE_CYCLES, then one
// GAP cycle with everything released. After the last GAP a single DONE
// cycle carries rsp_valid, and the block returns to IDLE.
//
// The field layout of the DRAM word and of the EBUS mapping is fixed by the
// IR board, so DRAM_ADDR_BITS and DRAM_WIDTH are expected to stay 9 and 15.
// ============================================================================
module dram_diag_loader #(
    parameter int DRAM_ADDR_BITS = 9,
    parameter int DRAM_WIDTH     = 15,
    parameter int SETTLE_CYCLES  = 1,
    parameter int STROBE_CYCLES  = 2,
    parameter bit VERIFY         = 1'b1
) (
    input  logic                       clk,
    input  logic                       CROBAR,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic                       req_write,
    input  logic [0:DRAM_ADDR_BITS-1]  req_addr,
    input  logic [0:DRAM_WIDTH-1]      req_data,
    output logic                       rsp_valid,
    output logic [0:DRAM_WIDTH-1]      rsp_data,
    output logic                       rsp_mismatch,
    output logic                       busy,
    output logic [0:6]                 DIAG_FUNC,
    output logic                       DIAG_STROBE,
    output logic                       ebus_drive,
    output logic [0:35]                ebus_data_out,
    input  logic [0:35]                ebus_data_in
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam int EBUS_WIDTH = 36;
    localparam int EBUS_USED  = 9;

    localparam int CNT_MAX  = (SETTLE_CYCLES > STROBE_CYCLES) ? SETTLE_CYCLES : STROBE_CYCLES;
    localparam int CNT_BITS = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_BITS-1:0] SETTLE_LAST = CNT_BITS'(SETTLE_CYCLES - 1);
    localparam logic [CNT_BITS-1:0] STROBE_LAST = CNT_BITS'(STROBE_CYCLES - 1);

    // Diagnostic function codes decoded by the IR board.
    localparam logic [0:6] FN_LDADR    = 7'o057;
    localparam logic [0:6] FN_XY_EVEN  = 7'o060;
    localparam logic [0:6] FN_XY_ODD   = 7'o061;
    localparam logic [0:6] FN_JC       = 7'o062;
    localparam logic [0:6] FN_JEO_EVEN = 7'o063;
    localparam logic [0:6] FN_JEO_ODD  = 7'o064;
    localparam logic [0:6] FN_R133     = 7'o133;
    localparam logic [0:6] FN_R134     = 7'o134;
    localparam logic [0:6] FN_R135     = 7'o135;

    // Step numbering: 0..3 are the load list, 4..7 the read list. A
    // readback request simply starts at step 4, so one counter covers all
    // three sequence shapes.
    localparam logic [2:0] STEP_FIRST_LOAD = 3'd0;
    localparam logic [2:0] STEP_FIRST_READ = 3'd4;
    localparam logic [2:0] STEP_LAST_LOAD  = 3'd3;
    localparam logic [2:0] STEP_LAST_READ  = 3'd7;
    localparam logic [2:0] STEP_R133       = 3'd5;
    localparam logic [2:0] STEP_R134       = 3'd6;
    localparam logic [2:0] STEP_R135       = 3'd7;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        GAP,
        DONE
    } stateT;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    stateT                      stateReg;
    logic [CNT_BITS-1:0]        cntReg;
    logic [2:0]                 stepReg;
    logic [2:0]                 lastStepReg;

    logic                       capWriteReg;
    logic [0:DRAM_ADDR_BITS-1]  capAddrReg;
    logic [0:DRAM_WIDTH-1]      capDataReg;
    logic [0:DRAM_WIDTH-1]      readbackReg;

    logic                       reqReadyReg;
    logic                       busyReg;
    logic                       rspValidReg;
    logic [0:DRAM_WIDTH-1]      rspDataReg;
    logic                       rspMismatchReg;
    logic [0:6]                 diagFuncReg;
    logic                       diagStrobeReg;
    logic                       ebusDriveReg;
    logic [0:EBUS_USED-1]       ebusWordReg;

    // ------------------------------------------------------------------
    // Step decode helpers
    // ------------------------------------------------------------------

    // Function code for a step. The XY and JEO loads address the even or
    // odd half of a DRAM pair through distinct codes selected by addr[8].
    function automatic logic [0:6] stepFunc(input logic [2:0] step, input logic oddAddr);
        logic [0:6] f;
        case (step)
            3'd0, 3'd4: f = FN_LDADR;
            3'd1:       f = oddAddr ? FN_XY_ODD : FN_XY_EVEN;
            3'd2:       f = FN_JC;
            3'd3:       f = oddAddr ? FN_JEO_ODD : FN_JEO_EVEN;
            3'd5:       f = FN_R133;
            3'd6:       f = FN_R134;
            default:    f = FN_R135;
        endcase
        return f;
    endfunction

    // The loader owns the EBUS for the address load and the three write
    // steps; during the R13x steps the IR board drives it.
    function automatic logic stepDrives(input logic [2:0] step);
        return (step <= STEP_FIRST_READ);
    endfunction

    // EBUS[0:8] image for a driving step. J fields are written left
    // justified on EBUS[0:3], although they are read back on EBUS[2:5].
    function automatic logic [0:EBUS_USED-1] stepWord(
        input logic [2:0]                step,
        input logic [0:DRAM_ADDR_BITS-1] addr,
        input logic [0:DRAM_WIDTH-1]     data
    );
        logic [0:EBUS_USED-1] w;
        case (step)
            3'd0, 3'd4: w = addr;
            3'd1:       w = {data[0:6], 2'b00};
            3'd2:       w = {data[7:10], 5'b00000};
            3'd3:       w = {data[11:14], 5'b00000};
            default:    w = '0;
        endcase
        return w;
    endfunction

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (CROBAR) begin
            stateReg       <= IDLE;
            cntReg         <= '0;
            stepReg        <= '0;
            lastStepReg    <= '0;
            capWriteReg    <= 1'b0;
            capAddrReg     <= '0;
            capDataReg     <= '0;
            readbackReg    <= '0;
            reqReadyReg    <= 1'b1;
            busyReg        <= 1'b0;
            rspValidReg    <= 1'b0;
            rspDataReg     <= '0;
            rspMismatchReg <= 1'b0;
            diagFuncReg    <= '0;
            diagStrobeReg  <= 1'b0;
            ebusDriveReg   <= 1'b0;
            ebusWordReg    <= '0;
        end else begin
            case (stateReg)
                IDLE: begin
                    if (req_valid) begin
                        // Capture the request and present the first step
                        // straight away so SETUP already carries it.
                        capWriteReg <= req_write;
                        capAddrReg  <= req_addr;
                        capDataReg  <= req_data;
                        readbackReg <= '0;
                        if (req_write) begin
                            stepReg      <= STEP_FIRST_LOAD;
                            lastStepReg  <= VERIFY ? STEP_LAST_READ : STEP_LAST_LOAD;
                            diagFuncReg  <= stepFunc(STEP_FIRST_LOAD, req_addr[DRAM_ADDR_BITS-1]);
                            ebusDriveReg <= 1'b1;
                            ebusWordReg  <= stepWord(STEP_FIRST_LOAD, req_addr, req_data);
                        end else begin
                            stepReg      <= STEP_FIRST_READ;
                            lastStepReg  <= STEP_LAST_READ;
                            diagFuncReg  <= stepFunc(STEP_FIRST_READ, req_addr[DRAM_ADDR_BITS-1]);
                            ebusDriveReg <= 1'b1;
                            ebusWordReg  <= stepWord(STEP_FIRST_READ, req_addr, req_data);
                        end
                        cntReg      <= '0;
                        reqReadyReg <= 1'b0;
                        busyReg     <= 1'b1;
                        stateReg    <= SETUP;
                    end
                end

                SETUP: begin
                    if (cntReg == SETTLE_LAST) begin
                        cntReg        <= '0;
                        diagStrobeReg <= 1'b1;
                        stateReg      <= STROBE;
                    end else begin
                        cntReg <= cntReg + 1'b1;
                    end
                end

                STROBE: begin
                    if (cntReg == STROBE_LAST) begin
                        // Readback fields are taken on the final strobe
                        // cycle, after the IR board has had the whole
                        // strobe to put the DRAM data on the bus.
                        case (stepReg)
                            STEP_R133: begin
                                readbackReg[0:2] <= ebus_data_in[0:2];
                                readbackReg[3:5] <= ebus_data_in[3:5];
                            end
                            STEP_R134: begin
                                readbackReg[7:10] <= ebus_data_in[2:5];
                            end
                            STEP_R135: begin
                                readbackReg[6]     <= ebus_data_in[0];
                                readbackReg[11:14] <= ebus_data_in[2:5];
                            end
                            default: ;
                        endcase
                        cntReg        <= '0;
                        diagStrobeReg <= 1'b0;
                        ebusDriveReg  <= 1'b0;
                        ebusWordReg   <= '0;
                        diagFuncReg   <= '0;
                        stateReg      <= GAP;
                    end else begin
                        cntReg <= cntReg + 1'b1;
                    end
                end

                GAP: begin
                    if (stepReg == lastStepReg) begin
                        rspValidReg <= 1'b1;
                        // An unverified load has nothing read back, so the
                        // response echoes the captured word instead.
                        if (capWriteReg && !VERIFY) begin
                            rspDataReg     <= capDataReg;
                            rspMismatchReg <= 1'b0;
                        end else begin
                            rspDataReg     <= readbackReg;
                            rspMismatchReg <= capWriteReg && (readbackReg != capDataReg);
                        end
                        stateReg <= DONE;
                    end else begin
                        stepReg      <= stepReg + 3'd1;
                        diagFuncReg  <= stepFunc(stepReg + 3'd1, capAddrReg[DRAM_ADDR_BITS-1]);
                        ebusDriveReg <= stepDrives(stepReg + 3'd1);
                        ebusWordReg  <= stepDrives(stepReg + 3'd1)
                                        ? stepWord(stepReg + 3'd1, capAddrReg, capDataReg)
                                        : '0;
                        stateReg     <= SETUP;
                    end
                end

                DONE: begin
                    // The step counter only ever restarts from here.
                    stepReg        <= '0;
                    rspValidReg    <= 1'b0;
                    rspDataReg     <= '0;
                    rspMismatchReg <= 1'b0;
                    reqReadyReg    <= 1'b1;
                    busyReg        <= 1'b0;
                    stateReg       <= IDLE;
                end

                default: begin
                    stateReg    <= IDLE;
                    reqReadyReg <= 1'b1;
                    busyReg     <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign req_ready    = reqReadyReg;
    assign busy         = busyReg;
    assign rsp_valid    = rspValidReg;
    assign rsp_data     = rspDataReg;
    assign rsp_mismatch = rspMismatchReg;
    assign DIAG_FUNC    = diagFuncReg;
    assign DIAG_STROBE  = diagStrobeReg;
    assign ebus_drive   = ebusDriveReg;

    // Only the low-numbered EBUS bits carry loader data; the rest are tied
    // off so the bus sees clean zeros.
    generate
        for (genvar gi = 0; gi < EBUS_WIDTH; gi++) begin : gEbusOut
            if (gi < EBUS_USED) begin : gUsed
                assign ebus_data_out[gi] = ebusWordReg[gi];
            end else begin : gTied
                assign ebus_data_out[gi] = 1'b0;
            end
        end
    endgenerate

    // EBUS receive bits beyond [0:5] carry nothing the DRAM readback needs.
    logic unusedEbusIn;
    assign unusedEbusIn = ^ebus_data_in[6:35];

endmodule

// File: tb/tb_dram_diag_loader.sv
`timescale 1ns/1ps
// Self-checking bench for dram_diag_loader. A small behavioural model of the
// IR board's DRAM answers the diag functions: it latches the address on 057,
// stores the fields written by 060-064 and returns them on 133-135.
module tb_dram_diag_loader;

    logic        clk = 1'b0;
    logic        CROBAR;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [0:8]  req_addr;
    logic [0:14] req_data;
    logic        rsp_valid;
    logic [0:14] rsp_data;
    logic        rsp_mismatch;
    logic        busy;
    logic [0:6]  DIAG_FUNC;
    logic        DIAG_STROBE;
    logic        ebus_drive;
    logic [0:35] ebus_data_out;
    logic [0:35] ebus_data_in;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    dram_diag_loader #(
        .DRAM_ADDR_BITS(9),
        .DRAM_WIDTH    (15),
        .SETTLE_CYCLES (1),
        .STROBE_CYCLES (2),
        .VERIFY        (1'b1)
    ) dut (
        .clk          (clk),
        .CROBAR       (CROBAR),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_addr     (req_addr),
        .req_data     (req_data),
        .rsp_valid    (rsp_valid),
        .rsp_data     (rsp_data),
        .rsp_mismatch (rsp_mismatch),
        .busy         (busy),
        .DIAG_FUNC    (DIAG_FUNC),
        .DIAG_STROBE  (DIAG_STROBE),
        .ebus_drive   (ebus_drive),
        .ebus_data_out(ebus_data_out),
        .ebus_data_in (ebus_data_in)
    );

    // ------------------------------------------------------------------
    // IR board DRAM model
    // ------------------------------------------------------------------
    logic [0:14] modelMem [0:511];
    logic [0:8]  modelAddr = '0;
    logic        flipP = 1'b0;
    logic        presetEn = 1'b0;
    logic [0:14] presetWord = '0;
    logic [0:14] modelWord;

    always @(posedge clk) begin
        if (DIAG_STROBE && ebus_drive) begin
            case (DIAG_FUNC)
                7'o057:         modelAddr <= ebus_data_out[0:8];
                7'o060, 7'o061: modelMem[modelAddr][0:6]   <= ebus_data_out[0:6];
                7'o062:         modelMem[modelAddr][7:10]  <= ebus_data_out[0:3];
                7'o063, 7'o064: modelMem[modelAddr][11:14] <= ebus_data_out[0:3];
                default: ;
            endcase
        end
    end

    always_comb begin
        modelWord    = presetEn ? presetWord : modelMem[modelAddr];
        ebus_data_in = '0;
        case (DIAG_FUNC)
            7'o133: begin
                ebus_data_in[0:2] = modelWord[0:2];
                ebus_data_in[3:5] = modelWord[3:5];
            end
            7'o134: ebus_data_in[2:5] = modelWord[7:10];
            7'o135: begin
                ebus_data_in[0]   = modelWord[6] ^ flipP;
                ebus_data_in[2:5] = modelWord[11:14];
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Bus monitor: logs function code per strobe and bus activity
    // ------------------------------------------------------------------
    logic [0:6] funcLog [0:127];
    int         funcCount = 0;
    int         strobeCycles = 0;
    int         readDriveViol = 0;
    logic       prevStrobe = 1'b0;
    logic [0:8] ldadrAddr = '0;
    logic       ldadrDrive = 1'b0;

    always @(negedge clk) begin
        if (DIAG_STROBE && !prevStrobe) begin
            if (funcCount < 128) funcLog[funcCount] <= DIAG_FUNC;
            funcCount <= funcCount + 1;
        end
        if (DIAG_STROBE) strobeCycles <= strobeCycles + 1;
        if (DIAG_STROBE && DIAG_FUNC == 7'o057) begin
            ldadrAddr  <= ebus_data_out[0:8];
            ldadrDrive <= ebus_drive;
        end
        if ((DIAG_FUNC == 7'o133 || DIAG_FUNC == 7'o134 || DIAG_FUNC == 7'o135) && ebus_drive)
            readDriveViol <= readDriveViol + 1;
        prevStrobe <= DIAG_STROBE;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Issue one request from a negedge while the DUT is idle; returns the
    // cycle (1 = first cycle after the accept edge) in which rsp_valid was
    // seen, or -1 on timeout. Leaves the bench at the first idle negedge.
    task automatic runReq(input logic w, input logic [0:8] a, input logic [0:14] d,
                          output int lat, output logic [0:14] rd, output logic mm);
        lat = -1; rd = '0; mm = 1'b0;
        req_write = w; req_addr = a; req_data = d; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            if (rsp_valid) begin
                lat = k; rd = rsp_data; mm = rsp_mismatch;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        CROBAR = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_data = '0;
        repeat (2) @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin fails++; $display("FAIL reset_req_ready: got %b expected 1", req_ready); end
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (DIAG_STROBE !== 1'b0) begin fails++; $display("FAIL reset_strobe: got %b expected 0", DIAG_STROBE); end
        checks++; if (ebus_drive !== 1'b0) begin fails++; $display("FAIL reset_drive: got %b expected 0", ebus_drive); end
        checks++; if (DIAG_FUNC !== 7'o000) begin fails++; $display("FAIL reset_func: got %o expected 0", DIAG_FUNC); end
        checks++; if (rsp_valid !== 1'b0 || ebus_data_out !== 36'd0) begin fails++; $display("FAIL reset_rsp_ebus: got rsp_valid=%b ebus=%o expected 0/0", rsp_valid, ebus_data_out); end
        CROBAR = 1'b0;
        @(negedge clk);
        checks++; if (req_ready !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL post_reset_idle: got ready=%b busy=%b expected 1/0", req_ready, busy); end
        $display("reset: checks=%0d fails=%0d", checks, fails);
    endtask

    task automatic test_load_verify();
        int lat; logic [0:14] rd; logic mm; int fc0; int sc0; int rv0;
        logic [0:6] expF [0:7];
        expF = '{7'o057, 7'o060, 7'o062, 7'o063, 7'o057, 7'o133, 7'o134, 7'o135};
        fc0 = funcCount; sc0 = strobeCycles; rv0 = readDriveViol;
        checks++; if (req_ready !== 1'b1) begin fails++; $display("FAIL verify_ready: got %b expected 1", req_ready); end
        runReq(1'b1, 9'o254, 15'o12345, lat, rd, mm);
        checks++; if (lat !== 33) begin fails++; $display("FAIL verify_latency: got %0d expected 33", lat); end
        checks++; if (rd !== 15'o12345) begin fails++; $display("FAIL verify_rsp_data: got %o expected 12345", rd); end
        checks++; if (mm !== 1'b0) begin fails++; $display("FAIL verify_mismatch: got %b expected 0", mm); end
        checks++; if (funcCount - fc0 !== 8) begin fails++; $display("FAIL verify_strobe_count: got %0d expected 8", funcCount - fc0); end
        for (int i = 0; i < 8; i++) begin
            checks++; if (funcLog[fc0 + i] !== expF[i]) begin fails++; $display("FAIL verify_func[%0d]: got %o expected %o", i, funcLog[fc0 + i], expF[i]); end
        end
        checks++; if (strobeCycles - sc0 !== 16) begin fails++; $display("FAIL verify_strobe_cycles: got %0d expected 16", strobeCycles - sc0); end
        checks++; if (ldadrAddr !== 9'o254 || ldadrDrive !== 1'b1) begin fails++; $display("FAIL verify_ldadr: got addr=%o drive=%b expected 254/1", ldadrAddr, ldadrDrive); end
        checks++; if (readDriveViol - rv0 !== 0) begin fails++; $display("FAIL verify_read_drive: got %0d driven read cycles expected 0", readDriveViol - rv0); end
        $display("load_verify addr=254 data=12345: lat=%0d rsp=%o mm=%b", lat, rd, mm);
    endtask

    task automatic test_odd_mismatch();
        int lat; logic [0:14] rd; logic mm; int fc0;
        logic [0:14] expD;
        logic [0:6] expF [0:7];
        expF = '{7'o057, 7'o061, 7'o062, 7'o064, 7'o057, 7'o133, 7'o134, 7'o135};
        expD = 15'o12345; expD[6] = ~expD[6];
        fc0 = funcCount;
        flipP = 1'b1;
        runReq(1'b1, 9'o255, 15'o12345, lat, rd, mm);
        flipP = 1'b0;
        checks++; if (lat !== 33) begin fails++; $display("FAIL odd_latency: got %0d expected 33", lat); end
        checks++; if (mm !== 1'b1) begin fails++; $display("FAIL odd_mismatch: got %b expected 1", mm); end
        checks++; if (rd !== expD) begin fails++; $display("FAIL odd_rsp_data: got %o expected %o", rd, expD); end
        for (int i = 0; i < 8; i++) begin
            checks++; if (funcLog[fc0 + i] !== expF[i]) begin fails++; $display("FAIL odd_func[%0d]: got %o expected %o", i, funcLog[fc0 + i], expF[i]); end
        end
        $display("load_odd addr=255 flipped P: lat=%0d rsp=%o mm=%b", lat, rd, mm);
    endtask

    task automatic test_readback();
        int lat; logic [0:14] rd; logic mm; int fc0; int sc0; int rv0;
        logic [0:14] expW;
        logic [0:6] expF [0:3];
        expF = '{7'o057, 7'o133, 7'o134, 7'o135};
        expW = {3'o5, 3'o2, 1'b1, 4'o17, 4'o12};
        fc0 = funcCount; sc0 = strobeCycles; rv0 = readDriveViol;
        presetWord = {3'o5, 3'o2, 1'b1, 4'o17, 4'o12};
        presetEn = 1'b1;
        runReq(1'b0, 9'o777, 15'o0, lat, rd, mm);
        presetEn = 1'b0;
        checks++; if (lat !== 17) begin fails++; $display("FAIL read_latency: got %0d expected 17", lat); end
        checks++; if (rd !== expW) begin fails++; $display("FAIL read_rsp_data: got %o expected %o", rd, expW); end
        checks++; if (mm !== 1'b0) begin fails++; $display("FAIL read_mismatch: got %b expected 0", mm); end
        checks++; if (funcCount - fc0 !== 4) begin fails++; $display("FAIL read_strobe_count: got %0d expected 4", funcCount - fc0); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (funcLog[fc0 + i] !== expF[i]) begin fails++; $display("FAIL read_func[%0d]: got %o expected %o", i, funcLog[fc0 + i], expF[i]); end
        end
        checks++; if (strobeCycles - sc0 !== 8) begin fails++; $display("FAIL read_strobe_cycles: got %0d expected 8", strobeCycles - sc0); end
        checks++; if (ldadrAddr !== 9'o777) begin fails++; $display("FAIL read_ldadr: got %o expected 777", ldadrAddr); end
        checks++; if (readDriveViol - rv0 !== 0) begin fails++; $display("FAIL read_drive: got %0d driven read cycles expected 0", readDriveViol - rv0); end
        $display("readback addr=777: lat=%0d rsp=%o mm=%b", lat, rd, mm);
    endtask

    task automatic test_reset_midseq();
        int lat; logic [0:14] rd; logic mm; int rises; logic prevS; int rspSeen;
        rises = 0; prevS = 1'b0; rspSeen = 0;
        checks++; if (req_ready !== 1'b1) begin fails++; $display("FAIL midrst_ready: got %b expected 1", req_ready); end
        req_write = 1'b1; req_addr = 9'o300; req_data = 15'o07070; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            if (DIAG_STROBE && !prevS) rises++;
            prevS = DIAG_STROBE;
            if (rises == 3) break;
            @(negedge clk);
        end
        checks++; if (rises !== 3) begin fails++; $display("FAIL midrst_third_strobe: got %0d strobes expected 3", rises); end
        CROBAR = 1'b1;
        @(negedge clk);
        checks++; if (req_ready !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL midrst_idle: got ready=%b busy=%b expected 1/0", req_ready, busy); end
        checks++; if (DIAG_STROBE !== 1'b0 || ebus_drive !== 1'b0 || DIAG_FUNC !== 7'o000) begin fails++; $display("FAIL midrst_bus: got strobe=%b drive=%b func=%o expected 0/0/0", DIAG_STROBE, ebus_drive, DIAG_FUNC); end
        CROBAR = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (rsp_valid) rspSeen++;
            @(negedge clk);
        end
        checks++; if (rspSeen !== 0) begin fails++; $display("FAIL midrst_no_rsp: got %0d rsp_valid cycles expected 0", rspSeen); end
        checks++; if (req_ready !== 1'b1) begin fails++; $display("FAIL midrst_ready_after: got %b expected 1", req_ready); end
        runReq(1'b1, 9'o300, 15'o07070, lat, rd, mm);
        checks++; if (lat !== 33 || rd !== 15'o07070 || mm !== 1'b0) begin fails++; $display("FAIL midrst_rerun: got lat=%0d rsp=%o mm=%b expected 33/07070/0", lat, rd, mm); end
        $display("reset_midseq rerun addr=300: lat=%0d rsp=%o mm=%b", lat, rd, mm);
    endtask

    task automatic test_back_to_back();
        int lat1; int lat2; logic [0:14] rd1; logic [0:14] rd2; logic mm2; int readyBusy;
        lat1 = -1; lat2 = -1; rd1 = '0; rd2 = '0; mm2 = 1'b0; readyBusy = 0;
        req_write = 1'b1; req_addr = 9'o100; req_data = 15'o54321; req_valid = 1'b1;
        checks++; if (req_ready !== 1'b1) begin fails++; $display("FAIL b2b_ready_first: got %b expected 1", req_ready); end
        @(negedge clk);
        for (int k = 1; k <= 60; k++) begin
            // Changing the request while busy must not disturb the capture.
            if (k == 2) begin req_addr = 9'o101; req_data = 15'o11111; end
            if (busy && req_ready) readyBusy++;
            if (rsp_valid) begin lat1 = k; rd1 = rsp_data; break; end
            @(negedge clk);
        end
        checks++; if (lat1 !== 33 || rd1 !== 15'o54321) begin fails++; $display("FAIL b2b_first_rsp: got lat=%0d rsp=%o expected 33/54321", lat1, rd1); end
        checks++; if (readyBusy !== 0) begin fails++; $display("FAIL b2b_ready_while_busy: got %0d cycles expected 0", readyBusy); end
        req_write = 1'b0; req_addr = 9'o100; req_data = '0;
        @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin fails++; $display("FAIL b2b_accept_next_cycle: got ready=%b expected 1", req_ready); end
        @(negedge clk);
        req_valid = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            if (rsp_valid) begin lat2 = k; rd2 = rsp_data; mm2 = rsp_mismatch; break; end
            @(negedge clk);
        end
        @(negedge clk);
        checks++; if (lat2 !== 17 || rd2 !== 15'o54321 || mm2 !== 1'b0) begin fails++; $display("FAIL b2b_second_rsp: got lat=%0d rsp=%o mm=%b expected 17/54321/0", lat2, rd2, mm2); end
        $display("back_to_back: first lat=%0d rsp=%o, second lat=%0d rsp=%o", lat1, rd1, lat2, rd2);
    endtask

    initial begin
        CROBAR = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_data = '0;
        test_reset();
        test_load_verify();
        test_odd_mismatch();
        test_readback();
        test_reset_midseq();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
